// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational ALU
// between two requesters, with per-requester response registers.
module alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req0_b,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req0_op,
    input  logic [3:0]       req1_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp0_result,
    output logic [31:0]      rsp1_result,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic             busy
);

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
        logic             id;
    } iss_t;

    logic             cand;
    logic             drain;
    logic             accept;
    logic             last_grant;
    logic             iss_v;
    iss_t             iss;
    iss_t             nxt;
    logic [1:0]       rsp_v;
    logic [31:0]      rsp_res [2];
    logic [TAG_W-1:0] rsp_tg  [2];

    // A lone requester always wins; on conflict the one not granted last wins.
    always_comb begin
        cand = ~last_grant;
        unique case (1'b1)
            (req_valid == 2'b01): cand = 1'b0;
            (req_valid == 2'b10): cand = 1'b1;
            default:              cand = ~last_grant;
        endcase
    end

    always_comb begin
        if (cand) begin
            nxt = '{a: req1_a, b: req1_b, op: req1_op,
                    tag: req1_tag, id: 1'b1};
        end else begin
            nxt = '{a: req0_a, b: req0_b, op: req0_op,
                    tag: req0_tag, id: 1'b0};
        end
    end

    assign drain = iss_v
                 & (~rsp_v[iss.id] | rsp_ready[iss.id]);

    assign req_ready = (rst_n & (~iss_v | drain))
                     ? (cand ? 2'b10 : 2'b01)
                     : 2'b00;

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_v      <= 1'b0;
            iss        <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            iss_v      <= 1'b1;
            iss        <= nxt;
            last_grant <= cand;
        end else if (drain) begin
            iss_v      <= 1'b0;
        end
    end

    // A drain into a slot wins over its consume, so the slot stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_v      <= 2'b00;
            rsp_res[0] <= '0;
            rsp_res[1] <= '0;
            rsp_tg[0]  <= '0;
            rsp_tg[1]  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (drain && iss.id == 1'(i)) begin
                    rsp_v[i]   <= 1'b1;
                    rsp_res[i] <= alu_result;
                    rsp_tg[i]  <= iss.tag;
                end else if (rsp_ready[i]) begin
                    rsp_v[i]   <= 1'b0;
                end
            end
        end
    end

    assign alu_a       = iss.a;
    assign alu_b       = iss.b;
    assign alu_ctrl    = iss.op;
    assign rsp_valid   = rsp_v;
    assign rsp0_result = rsp_res[0];
    assign rsp1_result = rsp_res[1];
    assign rsp0_tag    = rsp_tg[0];
    assign rsp1_tag    = rsp_tg[1];
    assign busy        = iss_v | rsp_v[0] | rsp_v[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic
// scored against per-requester expected-result queues.
module tb_alu_arbiter;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [31:0]      ra [2];
    logic [31:0]      rb [2];
    logic [3:0]       rop [2];
    logic [TAG_W-1:0] rtag [2];
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_ctrl;
    logic [31:0]      alu_result;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp0_result;
    logic [31:0]      rsp1_result;
    logic [TAG_W-1:0] rsp0_tag;
    logic [TAG_W-1:0] rsp1_tag;
    logic             busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e;
    logic [1:0] fired = 2'b00;
    logic       m_last = 1'b1;

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(ra[0]), .req1_a(ra[1]),
        .req0_b(rb[0]), .req1_b(rb[1]),
        .req0_op(rop[0]), .req1_op(rop[1]),
        .req0_tag(rtag[0]), .req1_tag(rtag[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
        .rsp0_tag(rsp0_tag), .rsp1_tag(rsp1_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the external ALU.
    function automatic logic [31:0] alu_f(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0] op);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[4:0];
            4'h6: return a >> b[4:0];
            4'h7: return sa >>> b[4:0];
            4'h8: return {31'd0, sa < sb};
            4'h9: return {31'd0, a < b};
            4'hF: return b;
            default: return ~a;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard: handshakes seen mid-cycle complete at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_last = 1'b1;
            fired  = 2'b00;
        end else begin
            fired = req_valid & req_ready;
            if (req_ready != 2'b00)
                check("rdy_onehot", req_ready & (req_ready - 2'd1), 0);
            for (int i = 0; i < 2; i++) begin
                if (fired[i]) begin
                    if (req_valid == 2'b11)
                        check("rr_grant", 64'(i), 64'(!m_last));
                    m_last = 1'(i);
                    n_acc++;
                    e.res = alu_f(ra[i], rb[i], rop[i]);
                    e.tag = rtag[i];
                    if (i == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
            if (rsp_valid[0] && rsp_ready[0]) begin
                if (q0.size() == 0) begin
                    check("rsp0_extra", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("rsp0_res", rsp0_result, e.res);
                    check("rsp0_tag", rsp0_tag, e.tag);
                end
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                if (q1.size() == 0) begin
                    check("rsp1_extra", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("rsp1_res", rsp1_result, e.res);
                    check("rsp1_tag", rsp1_tag, e.tag);
                end
            end
        end
    end

    task automatic single(input int p, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op,
                          input logic [3:0] tg, input logic [31:0] exp,
                          input string nm);
        int t;
        ra[p]     = a;
        rb[p]     = b;
        rop[p]    = op;
        rtag[p]   = tg;
        rsp_ready = 2'b11;
        req_valid = (p == 0) ? 2'b01 : 2'b10;
        t = 0;
        @(negedge clk);
        while (!req_ready[p] && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_acc"}, req_ready[p], 1);
        step();
        req_valid = 2'b00;
        t = 0;
        @(negedge clk);
        while (!rsp_valid[p] && t < 20) begin
            @(negedge clk);
            t++;
        end
        check(nm, (p == 0) ? rsp0_result : rsp1_result, exp);
        step();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ra[i]   = '0;
            rb[i]   = '0;
            rop[i]  = '0;
            rtag[i] = '0;
        end
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        step();
        step();
        check("rst_ready", req_ready, 0);
        check("rst_rspv", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alu", {alu_a, alu_b}, 0);
        check("rst_ctrl", alu_ctrl, 0);
        check("rst_rsp", {rsp0_result, rsp1_tag}, 0);
        req_valid = 2'b00;
        rst_n     = 1'b1;

        // Single op latency
        step();
        ra[0] = 32'd5; rb[0] = 32'd3; rop[0] = 4'b0001; rtag[0] = 4'd2;
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        @(negedge clk);
        check("t1_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        check("t1_early", rsp_valid, 2'b00);
        check("t1_busy", busy, 1);
        step();
        @(negedge clk);
        check("t1_valid", rsp_valid, 2'b01);
        check("t1_result", rsp0_result, 32'd2);
        check("t1_tag", rsp0_tag, 4'd2);
        step();
        @(negedge clk);
        check("t1_done", rsp_valid, 2'b00);

        // Continuous contention
        do_reset();
        ra[0] = 32'd1;   rb[0] = 32'd2;   rop[0] = 4'h0; rtag[0] = 4'd3;
        ra[1] = 32'd100; rb[1] = 32'd200; rop[1] = 4'h0; rtag[1] = 4'd4;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("cont_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
            if (k >= 2)
                check("cont_rsp", rsp_valid, (k % 2) ? 2'b10 : 2'b01);
            step();
        end
        req_valid = 2'b00;
        step();
        step();

        // Backpressure, then consume and refill in one cycle
        do_reset();
        rsp_ready = 2'b10;
        ra[0] = 32'd10; rb[0] = 32'd1; rop[0] = 4'h0; rtag[0] = 4'd1;
        req_valid = 2'b01;
        @(negedge clk);
        check("bp_rdy1", req_ready, 2'b01);
        step();
        ra[0] = 32'd20; rb[0] = 32'd2; rop[0] = 4'h1; rtag[0] = 4'd2;
        @(negedge clk);
        check("bp_rdy2", req_ready, 2'b01);
        step();
        ra[0] = 32'hF0; rb[0] = 32'h3C; rop[0] = 4'h2; rtag[0] = 4'd3;
        ra[1] = 32'd7;  rb[1] = 32'd7;  rop[1] = 4'h0; rtag[1] = 4'd9;
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_stall", req_ready, 2'b00);
            check("bp_slot", rsp_valid, 2'b01);
            check("bp_slot_res", rsp0_result, 32'd11);
            step();
        end
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        @(negedge clk);
        check("bp_rdy3", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        check("bp_refill_v", rsp_valid[0], 1);
        check("bp_refill_res", rsp0_result, 32'd18);
        step();
        @(negedge clk);
        check("bp_third_v", rsp_valid[0], 1);
        check("bp_third_res", rsp0_result, 32'h30);
        step();
        @(negedge clk);
        check("bp_empty", rsp_valid, 2'b00);
        check("bp_sb_empty", q0.size(), 0);

        // Op passthrough
        single(1, 32'h12345678, 32'hDEADBEEF, 4'hF, 4'd5,
               32'hDEADBEEF, "pass_b");
        single(1, 32'h80000000, 32'd4, 4'h7, 4'd6,
               32'hF8000000, "sra");
        single(0, 32'd9, 32'd3, 4'h5, 4'd7, 32'd72, "sll");

        // Async reset with everything full
        do_reset();
        ra[0] = 32'd3; rb[0] = 32'd4; rop[0] = 4'h0; rtag[0] = 4'd1;
        ra[1] = 32'd5; rb[1] = 32'd6; rop[1] = 4'h0; rtag[1] = 4'd2;
        req_valid = 2'b11;
        repeat (4) step();
        @(negedge clk);
        check("full_rspv", rsp_valid, 2'b11);
        check("full_busy", busy, 1);
        check("full_ready", req_ready, 2'b00);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rspv", rsp_valid, 2'b00);
        check("arst_busy", busy, 0);
        check("arst_ready", req_ready, 2'b00);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_first", req_ready, 2'b01);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (4) step();

        // Randomized traffic
        n_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || fired[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    ra[i]   = $urandom;
                    rb[i]   = $urandom_range(0, 1) ? $urandom
                                                   : $urandom_range(0, 40);
                    rop[i]  = 4'($urandom);
                    rtag[i] = 4'($urandom);
                end
            end
            rsp_ready = 2'($urandom);
        end
        step();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (6) step();
        @(negedge clk);
        check("rand_q0_empty", q0.size(), 0);
        check("rand_q1_empty", q1.size(), 0);
        check("rand_idle", busy, 0);
        check("rand_activity", n_acc > 500, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
